// File: rtl/miss_fill_ctrl.sv
// miss_fill_ctrl: memory-side end of the MSHR protocol (miss queue to memory, fill return to bank).
// Optional build macro MISS_FILL_PERF_EN adds perf_misses / perf_lat_sum counters.
module miss_fill_ctrl #(
    parameter int MSHR_SIZE       = 4,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int CACHE_LINE_SIZE = 64,
    parameter int MSHR_ADDR_WIDTH = $clog2(MSHR_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         miss_valid,
    input  logic [MSHR_ADDR_WIDTH-1:0]   miss_id,
    input  logic [LINE_ADDR_WIDTH-1:0]   miss_addr,
    output logic                         miss_ready,
    output logic                         mem_req_valid,
    output logic [LINE_ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [MSHR_ADDR_WIDTH-1:0]   mem_req_tag,
    input  logic                         mem_req_ready,
    input  logic                         mem_rsp_valid,
    input  logic [MSHR_ADDR_WIDTH-1:0]   mem_rsp_tag,
    input  logic [CACHE_LINE_SIZE*8-1:0] mem_rsp_data,
    output logic                         mem_rsp_ready,
    output logic                         fill_valid,
    output logic [MSHR_ADDR_WIDTH-1:0]   fill_id,
    output logic [CACHE_LINE_SIZE*8-1:0] fill_data,
    input  logic                         fill_ready,
    output logic [MSHR_ADDR_WIDTH:0]     pending_cnt,
    output logic                         err_proto
`ifdef MISS_FILL_PERF_EN
    ,
    output logic [31:0]                  perf_misses,
    output logic [43:0]                  perf_lat_sum
`endif
);
    localparam int CntW = MSHR_ADDR_WIDTH + 1;
    localparam logic [MSHR_ADDR_WIDTH-1:0] PtrMax  = MSHR_ADDR_WIDTH'(MSHR_SIZE - 1);
    localparam logic [CntW-1:0]            CntFull = CntW'(MSHR_SIZE);

    logic [MSHR_ADDR_WIDTH-1:0]   idMem   [MSHR_SIZE];
    logic [LINE_ADDR_WIDTH-1:0]   addrMem [MSHR_SIZE];
    logic [MSHR_ADDR_WIDTH-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CntW-1:0]              count_q, count_d;
    logic [MSHR_SIZE-1:0]         pending_q, pending_d;
    logic [CntW-1:0]              pendCnt_q, pendCnt_d;
    logic                         fillValid_q, fillValid_d;
    logic [MSHR_ADDR_WIDTH-1:0]   fillId_q, fillId_d;
    logic [CACHE_LINE_SIZE*8-1:0] fillData_q, fillData_d;
    logic                         errProto_q, errProto_d;
    logic                         missFire, reqFire, rspFire, fillFire, rspHit, missDup;

    assign miss_ready    = (count_q != CntFull);
    assign mem_req_valid = (count_q != '0);
    assign mem_req_addr  = addrMem[rdPtr_q];
    assign mem_req_tag   = idMem[rdPtr_q];
    assign mem_rsp_ready = !fillValid_q || fill_ready;
    assign fill_valid    = fillValid_q;
    assign fill_id       = fillId_q;
    assign fill_data     = fillData_q;
    assign pending_cnt   = pendCnt_q;
    assign err_proto     = errProto_q;

    assign missFire = miss_valid && miss_ready;
    assign reqFire  = mem_req_valid && mem_req_ready;
    assign rspFire  = mem_rsp_valid && mem_rsp_ready;
    assign fillFire = fillValid_q && fill_ready;
    // A fill leaving this cycle already retired its id, so a second response for it is spurious.
    assign rspHit   = pending_q[mem_rsp_tag] && !(fillFire && (fillId_q == mem_rsp_tag));
    assign missDup  = pending_q[miss_id] && !(fillFire && (fillId_q == miss_id));

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (missFire) wrPtr_d = (wrPtr_q == PtrMax) ? '0 : wrPtr_q + MSHR_ADDR_WIDTH'(1);
        if (reqFire)  rdPtr_d = (rdPtr_q == PtrMax) ? '0 : rdPtr_q + MSHR_ADDR_WIDTH'(1);
        count_d = count_q + CntW'(missFire) - CntW'(reqFire);
    end

    // Clear-then-set lets a fill and a fresh miss on the same id coexist in one cycle.
    always_comb begin
        pending_d = pending_q;
        if (fillFire) pending_d[fillId_q] = 1'b0;
        if (missFire) pending_d[miss_id]  = 1'b1;
        pendCnt_d = '0;
        for (int i = 0; i < MSHR_SIZE; i++) pendCnt_d = pendCnt_d + CntW'(pending_d[i]);
    end

    always_comb begin
        fillValid_d = fillValid_q;
        fillId_d    = fillId_q;
        fillData_d  = fillData_q;
        if (fillFire) fillValid_d = 1'b0;
        if (rspFire && rspHit) begin
            fillValid_d = 1'b1;
            fillId_d    = mem_rsp_tag;
            fillData_d  = mem_rsp_data;
        end
        errProto_d = errProto_q || (missFire && missDup) || (rspFire && !rspHit);
    end

    always_ff @(posedge clk) begin
        if (missFire) begin
            idMem[wrPtr_q]   <= miss_id;
            addrMem[wrPtr_q] <= miss_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            pendCnt_q   <= '0;
            fillValid_q <= 1'b0;
            fillId_q    <= '0;
            fillData_q  <= '0;
            errProto_q  <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            pendCnt_q   <= pendCnt_d;
            fillValid_q <= fillValid_d;
            fillId_q    <= fillId_d;
            fillData_q  <= fillData_d;
            errProto_q  <= errProto_d;
        end
    end

`ifdef MISS_FILL_PERF_EN
    logic [31:0] perfMisses_q;
    logic [43:0] perfLatSum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perfMisses_q <= '0;
            perfLatSum_q <= '0;
        end else begin
            perfMisses_q <= perfMisses_q + 32'(reqFire);
            perfLatSum_q <= perfLatSum_q + 44'(pendCnt_q);
        end
    end

    assign perf_misses  = perfMisses_q;
    assign perf_lat_sum = perfLatSum_q;
`else
    // Performance counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_miss_fill_ctrl.sv
// tb_miss_fill_ctrl: directed self-checking bench for miss_fill_ctrl (default 4-entry build).
module tb_miss_fill_ctrl;
    localparam int AW = 2;
    localparam int LW = 26;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss_valid;
    logic [AW-1:0] miss_id;
    logic [LW-1:0] miss_addr;
    logic          miss_ready;
    logic          mem_req_valid;
    logic [LW-1:0] mem_req_addr;
    logic [AW-1:0] mem_req_tag;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [AW-1:0] mem_rsp_tag;
    logic [DW-1:0] mem_rsp_data;
    logic          mem_rsp_ready;
    logic          fill_valid;
    logic [AW-1:0] fill_id;
    logic [DW-1:0] fill_data;
    logic          fill_ready;
    logic [AW:0]   pending_cnt;
    logic          err_proto;

    int checks = 0;
    int errors = 0;

    miss_fill_ctrl dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_id(miss_id), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_ready(mem_rsp_ready),
        .fill_valid(fill_valid), .fill_id(fill_id), .fill_data(fill_data), .fill_ready(fill_ready),
        .pending_cnt(pending_cnt), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mkData(input int t);
        logic [31:0] w;
        w = 32'hDA7A_0000 + 32'(t);
        return {16{w}};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid got %b exp 0", mem_req_valid); end
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_fill_valid got %b exp 0", fill_valid); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("[TB] FAIL rst_pending_cnt got %0d exp 0", pending_cnt); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("[TB] FAIL rst_err_proto got %b exp 0", err_proto); end
        checks++; if (mem_rsp_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_rsp_ready got %b exp 1", mem_rsp_ready); end
        reset = 1'b0;
        step();
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_miss_ready got %b exp 1", miss_ready); end
    endtask

    task automatic test_single_miss;
        mem_req_ready = 1'b1;
        miss_valid = 1'b1; miss_id = 2'd2; miss_addr = 26'h1234;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_req_early got %b exp 0", mem_req_valid); end
        step();
        miss_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_req_valid got %b exp 1", mem_req_valid); end
        checks++; if (mem_req_addr !== 26'h1234) begin errors++; $display("[TB] FAIL single_req_addr got %h exp 1234", mem_req_addr); end
        checks++; if (mem_req_tag !== 2'd2) begin errors++; $display("[TB] FAIL single_req_tag got %0d exp 2", mem_req_tag); end
        checks++; if (pending_cnt !== 3'd1) begin errors++; $display("[TB] FAIL single_pcnt_up got %0d exp 1", pending_cnt); end
        step();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_req_done got %b exp 0", mem_req_valid); end
        mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd2; mem_rsp_data = mkData(2); fill_ready = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (fill_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_fill_valid got %b exp 1", fill_valid); end
        checks++; if (fill_id !== 2'd2) begin errors++; $display("[TB] FAIL single_fill_id got %0d exp 2", fill_id); end
        checks++; if (fill_data !== mkData(2)) begin errors++; $display("[TB] FAIL single_fill_data got %h exp %h", fill_data, mkData(2)); end
        step();
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_fill_done got %b exp 0", fill_valid); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("[TB] FAIL single_pcnt_down got %0d exp 0", pending_cnt); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("[TB] FAIL single_err got %b exp 0", err_proto); end
    endtask

    task automatic test_queue_full;
        logic [LW-1:0] addrs [4];
        addrs[0] = 26'h0A00; addrs[1] = 26'h0B11; addrs[2] = 26'h0C22; addrs[3] = 26'h0D33;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            miss_valid = 1'b1; miss_id = AW'(i); miss_addr = addrs[i];
            step();
        end
        checks++; if (miss_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_miss_ready got %b exp 0", miss_ready); end
        checks++; if (pending_cnt !== 3'd4) begin errors++; $display("[TB] FAIL full_pcnt got %0d exp 4", pending_cnt); end
        checks++; if (mem_req_addr !== addrs[0]) begin errors++; $display("[TB] FAIL full_head_addr got %h exp %h", mem_req_addr, addrs[0]); end
        // Fifth miss (reusing id 0) is presented while full and while the head dequeues.
        miss_valid = 1'b1; miss_id = 2'd0; miss_addr = 26'h0999; mem_req_ready = 1'b1;
        #1;
        checks++; if (miss_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_deq_ready got %b exp 0", miss_ready); end
        step();
        miss_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== addrs[i] || mem_req_tag !== AW'(i)) begin
                errors++; $display("[TB] FAIL full_order_%0d got v=%b addr=%h tag=%0d exp v=1 addr=%h tag=%0d", i, mem_req_valid, mem_req_addr, mem_req_tag, addrs[i], i);
            end
            step();
        end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drained got %b exp 0", mem_req_valid); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("[TB] FAIL full_fifth_err got %b exp 0", err_proto); end
        checks++; if (pending_cnt !== 3'd4) begin errors++; $display("[TB] FAIL full_pcnt_after got %0d exp 4", pending_cnt); end
    endtask

    task automatic test_out_of_order;
        int order [4];
        int rspIdx, fillIdx;
        logic accepted, stalled;
        logic [AW-1:0] stallId;
        logic [DW-1:0] stallData;
        order[0] = 3; order[1] = 1; order[2] = 0; order[3] = 2;
        rspIdx = 0; fillIdx = 0; stalled = 1'b0; stallId = '0; stallData = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (fillIdx == 4) break;
            if (stalled) begin
                checks++; if (fill_valid !== 1'b1 || fill_id !== stallId || fill_data !== stallData) begin
                    errors++; $display("[TB] FAIL ooo_hold got v=%b id=%0d exp v=1 id=%0d", fill_valid, fill_id, stallId);
                end
            end
            fill_ready = (cyc % 2 == 0);
            mem_rsp_valid = (rspIdx < 4);
            mem_rsp_tag = (rspIdx < 4) ? AW'(order[rspIdx]) : '0;
            mem_rsp_data = (rspIdx < 4) ? mkData(order[rspIdx]) : '0;
            #1;
            checks++; if (mem_rsp_ready !== (!fill_valid || fill_ready)) begin
                errors++; $display("[TB] FAIL ooo_rsp_ready got %b exp %b", mem_rsp_ready, (!fill_valid || fill_ready));
            end
            accepted = mem_rsp_valid && mem_rsp_ready;
            stalled = 1'b0;
            if (fill_valid === 1'b1) begin
                if (fill_ready) begin
                    checks++; if (fill_id !== AW'(order[fillIdx]) || fill_data !== mkData(order[fillIdx])) begin
                        errors++; $display("[TB] FAIL ooo_fill_%0d got id=%0d exp id=%0d", fillIdx, fill_id, order[fillIdx]);
                    end
                    fillIdx++;
                end else begin
                    stalled = 1'b1; stallId = fill_id; stallData = fill_data;
                end
            end
            step();
            if (accepted) rspIdx++;
        end
        mem_rsp_valid = 1'b0; fill_ready = 1'b1;
        checks++; if (fillIdx != 4) begin errors++; $display("[TB] FAIL ooo_fill_count got %0d exp 4", fillIdx); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("[TB] FAIL ooo_pcnt got %0d exp 0", pending_cnt); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("[TB] FAIL ooo_err got %b exp 0", err_proto); end
    endtask

    task automatic test_spurious_rsp;
        fill_ready = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd1; mem_rsp_data = mkData(9);
        #1;
        checks++; if (mem_rsp_ready !== 1'b1) begin errors++; $display("[TB] FAIL spur_ready got %b exp 1", mem_rsp_ready); end
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (err_proto !== 1'b1) begin errors++; $display("[TB] FAIL spur_err got %b exp 1", err_proto); end
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("[TB] FAIL spur_no_fill got %b exp 0", fill_valid); end
        checks++; if (mem_rsp_ready !== 1'b1) begin errors++; $display("[TB] FAIL spur_ready_after got %b exp 1", mem_rsp_ready); end
        step();
        checks++; if (err_proto !== 1'b1) begin errors++; $display("[TB] FAIL spur_sticky got %b exp 1", err_proto); end
    endtask

    task automatic test_same_cycle_fill_miss;
        reset = 1'b1; step(); reset = 1'b0; step();
        mem_req_ready = 1'b1;
        miss_valid = 1'b1; miss_id = 2'd0; miss_addr = 26'h0040;
        step();
        miss_valid = 1'b0;
        step();
        mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd0; mem_rsp_data = mkData(20); fill_ready = 1'b0;
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (fill_valid !== 1'b1 || fill_id !== 2'd0) begin errors++; $display("[TB] FAIL same_fill_pre got v=%b id=%0d exp v=1 id=0", fill_valid, fill_id); end
        fill_ready = 1'b1;
        miss_valid = 1'b1; miss_id = 2'd0; miss_addr = 26'h0080;
        step();
        miss_valid = 1'b0;
        checks++; if (err_proto !== 1'b0) begin errors++; $display("[TB] FAIL same_err got %b exp 0", err_proto); end
        checks++; if (pending_cnt !== 3'd1) begin errors++; $display("[TB] FAIL same_pcnt got %0d exp 1", pending_cnt); end
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("[TB] FAIL same_fill_gone got %b exp 0", fill_valid); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 26'h0080 || mem_req_tag !== 2'd0) begin
            errors++; $display("[TB] FAIL same_req got v=%b addr=%h tag=%0d exp v=1 addr=0080 tag=0", mem_req_valid, mem_req_addr, mem_req_tag);
        end
        step();
        mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd0; mem_rsp_data = mkData(21);
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (fill_valid !== 1'b1 || fill_data !== mkData(21)) begin errors++; $display("[TB] FAIL same_refill got v=%b data=%h exp v=1 data=%h", fill_valid, fill_data, mkData(21)); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("[TB] FAIL same_refill_err got %b exp 0", err_proto); end
        step();
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("[TB] FAIL same_pcnt_end got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_reset_inflight;
        mem_req_ready = 1'b1; fill_ready = 1'b1;
        miss_valid = 1'b1; miss_id = 2'd1; miss_addr = 26'h0100;
        step();
        miss_id = 2'd3; miss_addr = 26'h0300;
        step();
        miss_valid = 1'b0;
        checks++; if (pending_cnt !== 3'd2) begin errors++; $display("[TB] FAIL rinf_pcnt got %0d exp 2", pending_cnt); end
        reset = 1'b1;
        step();
        step();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rinf_req_valid got %b exp 0", mem_req_valid); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("[TB] FAIL rinf_pcnt_rst got %0d exp 0", pending_cnt); end
        checks++; if (fill_valid !== 1'b0 || err_proto !== 1'b0 || mem_rsp_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rinf_outs got fv=%b err=%b rr=%b exp fv=0 err=0 rr=1", fill_valid, err_proto, mem_rsp_ready);
        end
        reset = 1'b0;
        step();
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("[TB] FAIL rinf_miss_ready got %b exp 1", miss_ready); end
        mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd1; mem_rsp_data = mkData(1);
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (err_proto !== 1'b1) begin errors++; $display("[TB] FAIL rinf_stale_err got %b exp 1", err_proto); end
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("[TB] FAIL rinf_stale_fill got %b exp 0", fill_valid); end
    endtask

    initial begin
        reset = 1'b1; miss_valid = 1'b0; miss_id = '0; miss_addr = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_tag = '0; mem_rsp_data = '0;
        fill_ready = 1'b1;
        test_reset();
        test_single_miss();
        test_queue_full();
        test_out_of_order();
        test_spurious_rsp();
        test_same_cycle_fill_miss();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
